// File: rtl/rs_array.sv
// rs_array -- age-ordered reservation station with CDB wakeup.
//
// Purpose:
//   Holds up to DEPTH instructions waiting for their source operands. Entries
//   live in a collapsing queue in allocation order (index 0 is the oldest).
//   The oldest entry whose four operands are all resolved is presented on
//   execute_pkt. Result broadcasts on the CDB wake pending operands.
//
// Ports:
//   clk          single clock, all state changes on the rising edge
//   rst          synchronous active-high reset, clears everything
//   flush        drops every entry, overrides rs_we and alu_re
//   cache_stall  freezes allocation and issue; wakeup keeps running
//   rs_entry     instruction to allocate
//   rs_we        allocate rs_entry this cycle
//   rs_write_rdy at least one free entry (from registered occupancy only)
//   rs_read_rdy  execute_pkt holds a ready instruction and issue is allowed
//   execute_pkt  oldest ready entry, or all-zero when none is ready
//   alu_re       consumer accepts execute_pkt
//   cdb_ports    result broadcasts used for wakeup
//   occupancy    number of valid entries
//
// Handshake: a transfer happens on a rising edge where valid (rs_we /
// rs_read_rdy) and ready (rs_write_rdy / alu_re) are both high; a request
// without the matching ready is ignored and leaves state unchanged.

package uarch_pkg;
    localparam int PIPE_WIDTH = 2;
    localparam int TAG_W      = 6;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic              is_renamed;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } operand_t;

    typedef struct packed {
        logic             is_valid;
        logic [7:0]       opcode;
        logic [TAG_W-1:0] dest_tag;
        operand_t         src_0_a;
        operand_t         src_0_b;
        operand_t         src_1_a;
        operand_t         src_1_b;
    } instruction_t;

    typedef struct packed {
        logic              is_valid;
        logic [TAG_W-1:0]  dest_tag;
        logic [DATA_W-1:0] result;
        logic              exception;
    } writeback_packet_t;
endpackage

module rs_array
    import uarch_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int NUM_CDB = PIPE_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              cache_stall,
    input  instruction_t      rs_entry,
    input  logic              rs_we,
    output logic              rs_write_rdy,
    output logic              rs_read_rdy,
    output instruction_t      execute_pkt,
    input  logic              alu_re,
    input  writeback_packet_t cdb_ports [NUM_CDB],
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    instruction_t     entries_q [DEPTH];
    instruction_t     entries_d [DEPTH];
    instruction_t     woken     [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] ready;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [IDX_W-1:0] sel_idx;
    logic             any_ready;
    logic             do_alloc;
    logic             do_issue;
    logic [OCC_W-1:0] alloc_pos;
    instruction_t     alloc_entry;
    logic [NUM_CDB-1:0] cdb_exc;
    logic             unused_bits;

    // Resolve one operand against the CDB; the lowest matching port wins.
    // The exception flag plays no part in wakeup.
    function automatic operand_t wake_op(input operand_t op);
        operand_t r;
        logic     hit;
        r   = op;
        hit = 1'b0;
        for (int p = 0; p < NUM_CDB; p++) begin
            if (!hit && op.is_renamed && cdb_ports[p].is_valid &&
                cdb_ports[p].dest_tag == op.tag) begin
                r.data       = cdb_ports[p].result;
                r.is_renamed = 1'b0;
                hit          = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic instruction_t wake_instr(input instruction_t in);
        instruction_t r;
        r         = in;
        r.src_0_a = wake_op(in.src_0_a);
        r.src_0_b = wake_op(in.src_0_b);
        r.src_1_a = wake_op(in.src_1_a);
        r.src_1_b = wake_op(in.src_1_b);
        return r;
    endfunction

    // Readiness and oldest-ready selection use registered state only, so a
    // broadcast becomes visible on execute_pkt one cycle later.
    always_comb begin
        any_ready = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = wake_instr(entries_q[i]);
            ready[i] = valid_q[i] &&
                       !entries_q[i].src_0_a.is_renamed &&
                       !entries_q[i].src_0_b.is_renamed &&
                       !entries_q[i].src_1_a.is_renamed &&
                       !entries_q[i].src_1_b.is_renamed;
        end
        // Scan youngest to oldest so the last hit is the oldest ready entry.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_idx   = IDX_W'(i);
                any_ready = 1'b1;
            end
        end
    end

    always_comb begin
        execute_pkt = '0;
        if (any_ready) begin
            execute_pkt = entries_q[sel_idx];
        end
    end

    assign rs_read_rdy  = any_ready && !cache_stall;
    assign rs_write_rdy = occ_q < OCC_W'(DEPTH);
    assign occupancy    = occ_q;

    assign do_issue  = rs_read_rdy && alu_re && !flush;
    assign do_alloc  = rs_we && rs_write_rdy && !cache_stall && !flush;
    // A same-cycle issue frees a slot below the tail, so the new entry lands
    // one position closer to the head.
    assign alloc_pos = occ_q - OCC_W'(do_issue);

    always_comb begin
        alloc_entry          = wake_instr(rs_entry);
        alloc_entry.is_valid = 1'b1;
    end

    // Collapse: every slot at or above the issued one takes its younger
    // neighbour. Wakeup is applied to the value being moved, so an entry
    // shifting on the same edge it is woken keeps the result.
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (do_issue && IDX_W'(i) >= sel_idx) begin
                entries_d[i] = woken[i+1];
                valid_d[i]   = valid_q[i+1];
            end else begin
                entries_d[i] = woken[i];
                valid_d[i]   = valid_q[i];
            end
        end
        entries_d[DEPTH-1] = woken[DEPTH-1];
        valid_d[DEPTH-1]   = valid_q[DEPTH-1] && !do_issue;

        if (do_alloc) begin
            entries_d[alloc_pos[IDX_W-1:0]] = alloc_entry;
            valid_d[alloc_pos[IDX_W-1:0]]   = 1'b1;
        end

        occ_d = occ_q + OCC_W'(do_alloc) - OCC_W'(do_issue);
        if (flush) begin
            valid_d = '0;
            occ_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

    // Fields that intentionally carry no function here.
    always_comb begin
        for (int p = 0; p < NUM_CDB; p++) begin
            cdb_exc[p] = cdb_ports[p].exception;
        end
    end
    assign unused_bits = rs_entry.is_valid ^ (^cdb_exc);

endmodule

// File: doc/rs_array.md
RS_ARRAY -- requirements
Module: rs_array

Interface
REQ-001 The block SHALL be parameterised as follows, one per line:
- DEPTH, 4: number of reservation-station entries (power of two, >= 2).
- NUM_CDB, PIPE_WIDTH: number of CDB writeback ports snooped for wakeup.
REQ-002 The block SHALL have the following ports, one per line, using uarch_pkg types:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all entries.
- cache_stall  in  1  freeze allocation and issue.
- rs_entry  in  instruction_t  instruction to allocate.
- rs_we  in  1  allocate rs_entry this cycle.
- rs_write_rdy  out  1  at least one free entry.
- rs_read_rdy  out  1  execute_pkt holds a fully ready instruction.
- execute_pkt  out  instruction_t  oldest ready instruction.
- alu_re  in  1  consumer accepts execute_pkt.
- cdb_ports  in  writeback_packet_t[NUM_CDB]  result broadcasts.
- occupancy  out  $clog2(DEPTH)+1  number of valid entries.
REQ-003 Clocking SHALL use one clock; reset is synchronous and active-high.

Function
REQ-004 Each entry SHALL hold one instruction_t plus a valid bit; the operands are src_0_a, src_0_b, src_1_a and src_1_b.
REQ-005 An operand SHALL be pending when is_renamed=1 and resolved when is_renamed=0.
REQ-006 An entry SHALL be ready when it is valid and all four operands are resolved.
REQ-007 Allocation SHALL take effect at the edge where rs_we=1, rs_write_rdy=1, cache_stall=0 and flush=0.
REQ-008 rs_we while rs_write_rdy=0 SHALL be ignored with no state change.
REQ-009 rs_write_rdy SHALL be (occupancy < DEPTH), registered-state based only; same-cycle issue does not raise it.
REQ-010 Entries SHALL be kept in allocation (age) order via a collapsing queue: issue removes an entry and younger entries shift toward the head.
REQ-011 Issue selection SHALL pick the oldest ready entry; execute_pkt is combinational from registered entry state.
REQ-012 rs_read_rdy SHALL be 1 iff some entry is ready and cache_stall=0.
REQ-013 When no entry is ready, execute_pkt SHALL be all-zero (is_valid=0).
REQ-014 The selected entry SHALL be removed at the edge where rs_read_rdy=1 and alu_re=1.
REQ-015 alu_re while rs_read_rdy=0 SHALL be ignored.
REQ-016 Simultaneous allocate and issue SHALL both complete; occupancy remains unchanged.
REQ-017 Wakeup: for each valid, pending operand and each port p with cdb_ports[p].is_valid=1 and dest_tag==operand.tag, the operand SHALL latch data<=result and is_renamed<=0 at the next edge.
REQ-018 Wakeup SHALL ignore the exception field.
REQ-019 If multiple ports match one operand, the lowest port index SHALL win.
REQ-020 Wakeup SHALL continue during cache_stall.
REQ-021 Write-cycle capture: operands of rs_entry being allocated SHALL also be compared against same-cycle CDB and stored already resolved on a match.
REQ-022 A woken operand SHALL be visible on execute_pkt one cycle after the broadcast; there is no combinational CDB-to-issue bypass.
REQ-023 Minimum allocate-to-issue latency SHALL be one cycle: rs_read_rdy may assert in the cycle after the allocating edge.
REQ-024 Wakeup of an entry shifting in the same edge SHALL be applied to that entry at its new position (no lost wakeup).
REQ-025 flush=1 SHALL clear all valid bits at the edge and override rs_we and alu_re; the next cycle shows occupancy=0 and rs_write_rdy=1.
REQ-026 occupancy SHALL equal the count of valid entries after each edge and never exceed DEPTH.

Reset
REQ-027 rst=1 SHALL at the edge clear all valid bits and entry contents; it has priority over flush, rs_we, alu_re and CDB.
REQ-028 After reset: occupancy=0, rs_write_rdy=1, rs_read_rdy=0, execute_pkt=0.
REQ-029 Reset asserted mid-operation SHALL discard in-flight entries with no issue in that cycle's edge.

Verification
REQ-030 Single wakeup: allocate entry, all four srcs tag=8, is_renamed=1; two idle cycles; CDB[0] {valid, dest_tag=8, result=42} -> next cycle rs_read_rdy=1, all four srcs data=42 and is_renamed=0; alu_re=1 -> occupancy 0.
REQ-031 Fill: DEPTH=4, allocate 4 pending entries -> rs_write_rdy=0, occupancy=4; 5th rs_we ignored; issuing one entry -> rs_write_rdy=1 next cycle.
REQ-032 Age order: allocate A (tag 3), B (tag 5), C (resolved); broadcast 5 then 3; issue order C, B, A; occupancy steps 3,2,1,0.
REQ-033 Write-cycle capture: allocate entry with src tag 6 pending while CDB[1] {tag=6, result=17} -> rs_read_rdy=1 next cycle with data 17.
REQ-034 Port priority: CDB[0] and CDB[1] both tag=2, results 11/22 -> operand data=11.
REQ-035 Flush and stall: 3 entries with cache_stall=1 -> rs_read_rdy=0 while CDB wakeups still land; then flush=1 together with rs_we=1 -> occupancy=0, no allocation.
